// File: rtl/edram_pm_pkg.sv
// edram_pm_pkg: shared sequencer/power-manager states, default timeouts and bank decode helper
package edram_pm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAKE,
        S_ISSUE,
        S_WAIT_DONE,
        S_RESP
    } seq_state_e;

    typedef enum logic [1:0] {
        PMU_SLEEP,
        PMU_WAKING,
        PMU_ACTIVE,
        PMU_STANDBY
    } pmu_state_e;

    localparam int T_WAKE_TIMEOUT_DEF = 200;
    localparam int T_ARR_TIMEOUT_DEF  = 63;
    localparam int PMU_WAKE_CYCLES    = 50;
    localparam int PMU_IDLE_CYCLES    = 150;

    function automatic logic [15:0] bank_onehot(input logic [3:0] b);
        return 16'(1) << b;
    endfunction

endpackage

// File: rtl/bank_access_sequencer.sv
// bank_access_sequencer: wakes the target eDRAM bank, issues one array access and reports the result
module bank_access_sequencer
    import edram_pm_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 32,
    parameter int T_WAKE_TIMEOUT = T_WAKE_TIMEOUT_DEF,
    parameter int T_ARR_TIMEOUT  = T_ARR_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_bank,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic [15:0]       request_wakeup,
    output logic [15:0]       access_done,
    input  logic [15:0]       bank_active_status,
    output logic              arr_en,
    output logic              arr_we,
    output logic [3:0]        arr_bank,
    output logic [ADDR_W-1:0] arr_addr,
    output logic [DATA_W-1:0] arr_wdata,
    input  logic              arr_done,
    input  logic [DATA_W-1:0] arr_rdata
);

    localparam int T_MAX = (T_WAKE_TIMEOUT > T_ARR_TIMEOUT) ? T_WAKE_TIMEOUT : T_ARR_TIMEOUT;
    localparam int CNT_W = $clog2(T_MAX) + 1;
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(T_WAKE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ARR_LAST  = CNT_W'(T_ARR_TIMEOUT - 1);

    seq_state_e        state_q;
    logic [3:0]        bank_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              error_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy;

    assign busy           = state_q inside {S_WAKE, S_ISSUE, S_WAIT_DONE};
    assign req_ready      = rst_n && state_q == S_IDLE;
    assign rsp_valid      = state_q == S_RESP;
    assign rsp_rdata      = rdata_q;
    assign rsp_error      = error_q;
    assign request_wakeup = busy ? bank_onehot(bank_q) : '0;
    assign access_done    = rsp_valid ? bank_onehot(bank_q) : '0;
    assign arr_en         = state_q == S_ISSUE;
    assign arr_we         = arr_en && we_q;
    assign arr_bank       = arr_en ? bank_q : '0;
    assign arr_addr       = arr_en ? addr_q : '0;
    assign arr_wdata      = arr_en ? wdata_q : '0;

    // The counter clears by default and only advances while a state persists,
    // so every state entry starts it from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bank_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= '0;
            case (state_q)
                S_IDLE: if (req_valid) begin
                    bank_q  <= req_bank;
                    we_q    <= req_we;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    state_q <= S_WAKE;
                end
                S_WAKE: if (bank_active_status[bank_q]) begin
                    state_q <= S_ISSUE;
                end else if (cnt_q == WAKE_LAST) begin
                    state_q <= S_RESP;
                    error_q <= 1'b1;
                    rdata_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_ISSUE: state_q <= S_WAIT_DONE;
                S_WAIT_DONE: if (arr_done) begin
                    state_q <= S_RESP;
                    error_q <= 1'b0;
                    rdata_q <= we_q ? '0 : arr_rdata;
                end else if (cnt_q == ARR_LAST) begin
                    state_q <= S_RESP;
                    error_q <= 1'b1;
                    rdata_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_RESP: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
